// File: rtl/mr_pkg.sv
// Shared definitions for the mr core bus fabric: arbiter state encoding and
// master index constants used by the Wishbone arbiter and its helpers.
package mr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1,
    ARB_DRAIN
  } e_arbstate;

  // Master indices; m0 is the instruction-fetch port, m1 the load/store port.
  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  function automatic logic other_master(input logic m);
    return ~m;
  endfunction

endpackage

// File: rtl/mr_wb_outst_ctr.sv
// Saturating up/down counter tracking accepted-but-unanswered Wishbone
// transfers for the current grant, with full/empty flags and a sync clear.
module mr_wb_outst_ctr #(
  parameter  int MAX_OUTST = 4,
  localparam int CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic do_inc;
  logic do_dec;

  assign full   = (count == CW'(MAX_OUTST));
  assign empty  = (count == '0);
  assign do_inc = inc & ~full;
  assign do_dec = dec & ~empty;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (do_inc && !do_dec) begin
      count <= count + CW'(1);
    end else if (do_dec && !do_inc) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mr_wb_arb.sv
// Two-master to one-slave pipelined Wishbone B4 arbiter: round-robin grant,
// per-grant outstanding tracking for response routing, starvation guard.
module mr_wb_arb
  import mr_pkg::*;
#(
  parameter int ADR_W      = 30,
  parameter int DAT_W      = 32,
  parameter int MAX_OUTST  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  input  logic               m0_we_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  input  logic               m0_stb_i,
  input  logic               m0_cyc_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  output logic               m0_stall_o,

  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  input  logic               m1_we_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  input  logic               m1_stb_i,
  input  logic               m1_cyc_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               m1_stall_o,

  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W-1:0]   s_dat_o,
  output logic               s_we_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  output logic               s_stb_o,
  output logic               s_cyc_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_stall_i
);

  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int SW  = $clog2(STARVE_LIM + 1);

  e_arbstate      state;
  logic           holder;
  logic           last_grant;
  logic [SW-1:0]  starve_cnt;

  logic [OCW-1:0] outst;
  logic           outst_full;
  logic           outst_empty;

  logic           own;
  logic           active;
  logic           h_cyc;
  logic           h_stb;
  logic           o_cyc;
  logic           grant_sel;
  logic           accept;
  logic           resp_ok;
  logic           rel;
  logic           h_stall;

  assign own    = (state == ARB_OWN0) || (state == ARB_OWN1);
  assign active = own || (state == ARB_DRAIN);

  assign h_cyc  = (holder == MST_M1) ? m1_cyc_i : m0_cyc_i;
  assign h_stb  = (holder == MST_M1) ? m1_stb_i : m0_stb_i;
  assign o_cyc  = (other_master(holder) == MST_M1) ? m1_cyc_i : m0_cyc_i;

  // On a tie the master that did not hold the bus last wins.
  assign grant_sel = (m0_cyc_i && m1_cyc_i) ? other_master(last_grant) : m1_cyc_i;

  assign s_adr_o = (holder == MST_M1) ? m1_adr_i : m0_adr_i;
  assign s_dat_o = (holder == MST_M1) ? m1_dat_i : m0_dat_i;
  assign s_we_o  = (holder == MST_M1) ? m1_we_i  : m0_we_i;
  assign s_sel_o = (holder == MST_M1) ? m1_sel_i : m0_sel_i;

  // cyc follows the holder combinationally so an abort reaches the slave at once.
  assign s_cyc_o = active & h_cyc;
  assign s_stb_o = own & h_cyc & h_stb & ~outst_full;

  assign accept  = s_stb_o & ~s_stall_i;
  assign rel     = active & ~h_cyc;

  // Responses with nothing outstanding, or after an abort, are swallowed.
  assign resp_ok = s_cyc_o & ~outst_empty;

  assign h_stall    = ~own | s_stall_i | outst_full;
  assign m0_stall_o = (active && holder == MST_M0) ? h_stall : 1'b1;
  assign m1_stall_o = (active && holder == MST_M1) ? h_stall : 1'b1;

  assign m0_ack_o = s_ack_i & resp_ok & (holder == MST_M0);
  assign m1_ack_o = s_ack_i & resp_ok & (holder == MST_M1);
  assign m0_err_o = s_err_i & resp_ok & (holder == MST_M0);
  assign m1_err_o = s_err_i & resp_ok & (holder == MST_M1);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  mr_wb_outst_ctr #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst (
    .clk   (clk),
    .rst   (rst),
    .clr   (rel),
    .inc   (accept),
    .dec   (resp_ok & (s_ack_i | s_err_i)),
    .count (outst),
    .full  (outst_full),
    .empty (outst_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      holder     <= MST_M0;
      last_grant <= MST_M1;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            state      <= (grant_sel == MST_M1) ? ARB_OWN1 : ARB_OWN0;
            holder     <= grant_sel;
            starve_cnt <= '0;
          end
        end

        ARB_OWN0, ARB_OWN1: begin
          if (!h_cyc) begin
            state      <= ARB_IDLE;
            last_grant <= holder;
            starve_cnt <= '0;
          end else if (accept && o_cyc) begin
            starve_cnt <= starve_cnt + SW'(1);
            if (starve_cnt == SW'(STARVE_LIM - 1)) begin
              state <= ARB_DRAIN;
            end
          end
        end

        ARB_DRAIN: begin
          // Leaving via IDLE with last_grant = holder hands the bus to the waiter.
          if (!h_cyc || outst == '0) begin
            state      <= ARB_IDLE;
            last_grant <= holder;
            starve_cnt <= '0;
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed self-checking bench for mr_wb_arb: single master, tie, outstanding
// limit, starvation drain, abort with late ack, and async reset mid-burst.
module tb_mr_wb_arb;

  logic        clk;
  logic        rst;
  logic [29:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_we_i, m1_we_i, s_we_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_stall_o, m1_stall_o;
  logic        s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_stall_i;

  int n_checks = 0;
  int n_pass   = 0;

  mr_wb_arb dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_stall_i(s_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_adr_i = '0; m0_dat_i = 32'h0000_00A0; m0_we_i = 1'b0; m0_sel_i = 4'hF;
    m1_adr_i = '0; m1_dat_i = 32'h0000_00B1; m1_we_i = 1'b0; m1_sel_i = 4'hF;
    m0_stb_i = 1'b0; m0_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b1; s_err_i = 1'b0; s_stall_i = 1'b0;

    // Reset values
    settle();
    check("rst_s_cyc", 32'(s_cyc_o), 0);
    check("rst_s_stb", 32'(s_stb_o), 0);
    check("rst_m0_stall", 32'(m0_stall_o), 1);
    check("rst_m1_stall", 32'(m1_stall_o), 1);
    check("rst_ack_dropped", 32'({m0_ack_o, m1_ack_o}), 0);
    s_ack_i = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Single master m1 read of 0x100 with a 2-cycle slave
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 30'h100; m1_sel_i = 4'h5;
    settle();
    check("single_lat_cyc", 32'(s_cyc_o), 0);
    check("single_lat_stall", 32'(m1_stall_o), 1);
    step();
    settle();
    check("single_cyc", 32'(s_cyc_o), 1);
    check("single_stb", 32'(s_stb_o), 1);
    check("single_adr", 32'(s_adr_o), 32'h100);
    check("single_sel", 32'(s_sel_o), 32'h5);
    check("single_m1_stall", 32'(m1_stall_o), 0);
    check("single_m0_stall", 32'(m0_stall_o), 1);
    step();
    m1_stb_i = 1'b0;
    settle();
    check("single_wait_ack", 32'(m1_ack_o), 0);
    step();
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    check("single_ack", 32'(m1_ack_o), 1);
    check("single_dat", m1_dat_o, 32'hDEAD_BEEF);
    check("single_m0_noack", 32'(m0_ack_o), 0);
    check("single_m0_stall2", 32'(m0_stall_o), 1);
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0;
    settle();
    check("single_release_cyc", 32'(s_cyc_o), 0);
    step();

    // Tie right after reset: m0 first, then m1
    rst = 1'b0;
    settle();
    rst = 1'b1;
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 30'h010;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 30'h020;
    settle();
    check("tie_idle_cyc", 32'(s_cyc_o), 0);
    step();
    settle();
    check("tie_cyc", 32'(s_cyc_o), 1);
    check("tie_adr_m0", 32'(s_adr_o), 32'h010);
    check("tie_m0_stall", 32'(m0_stall_o), 0);
    check("tie_m1_stall", 32'(m1_stall_o), 1);
    step();
    m0_stb_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    settle();
    check("tie_m0_ack", 32'(m0_ack_o), 1);
    check("tie_m1_noack", 32'(m1_ack_o), 0);
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0;
    settle();
    check("tie_m0_drop_cyc", 32'(s_cyc_o), 0);
    step();
    settle();
    check("tie_idle_gap", 32'(s_cyc_o), 0);
    step();
    settle();
    check("tie_m1_cyc", 32'(s_cyc_o), 1);
    check("tie_adr_m1", 32'(s_adr_o), 32'h020);
    check("tie_m1_stall_low", 32'(m1_stall_o), 0);
    check("tie_m0_stall_high", 32'(m0_stall_o), 1);
    step();
    m1_stb_i = 1'b0; s_ack_i = 1'b1;
    settle();
    check("tie_m1_ack", 32'(m1_ack_o), 1);
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0;
    step();

    // Outstanding limit: slave never acks, m0 strobes 6 times
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 30'h040;
    step();
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("outst_accept%0d_stall", i), 32'(m0_stall_o), 0);
      check($sformatf("outst_accept%0d_stb", i), 32'(s_stb_o), 1);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("outst_full%0d_stall", i), 32'(m0_stall_o), 1);
      check($sformatf("outst_full%0d_stb", i), 32'(s_stb_o), 0);
      step();
    end
    s_ack_i = 1'b1;
    settle();
    check("outst_ack_fwd", 32'(m0_ack_o), 1);
    check("outst_ack_still_full", 32'(m0_stall_o), 1);
    step();
    s_ack_i = 1'b0;
    settle();
    check("outst_one_more_stall", 32'(m0_stall_o), 0);
    check("outst_one_more_stb", 32'(s_stb_o), 1);
    step();
    settle();
    check("outst_refull_stall", 32'(m0_stall_o), 1);
    check("outst_refull_stb", 32'(s_stb_o), 0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();

    // Starvation: m0 streams, m1 waits, forced release after 8 accepts
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 30'h080;
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 30'h0C0;
    settle();
    check("starve_own0_adr", 32'(s_adr_o), 32'h080);
    for (int i = 1; i < 8; i++) begin
      step();
      s_ack_i = 1'b1;
      settle();
      check($sformatf("starve_stream%0d_stall", i), 32'(m0_stall_o), 0);
      check($sformatf("starve_stream%0d_ack", i), 32'(m0_ack_o), 1);
    end
    step();
    settle();
    check("drain_m0_stall", 32'(m0_stall_o), 1);
    check("drain_stb", 32'(s_stb_o), 0);
    check("drain_cyc", 32'(s_cyc_o), 1);
    check("drain_ack_to_m0", 32'(m0_ack_o), 1);
    check("drain_m1_stall", 32'(m1_stall_o), 1);
    step();
    s_ack_i = 1'b0;
    settle();
    check("drain_wait_cyc", 32'(s_cyc_o), 1);
    check("drain_wait_stall", 32'(m0_stall_o), 1);
    step();
    settle();
    check("drain_idle_cyc", 32'(s_cyc_o), 0);
    check("drain_idle_m0_stall", 32'(m0_stall_o), 1);
    step();
    settle();
    check("drain_m1_grant_cyc", 32'(s_cyc_o), 1);
    check("drain_m1_grant_adr", 32'(s_adr_o), 32'h0C0);
    check("drain_m1_stall", 32'(m1_stall_o), 0);
    check("drain_m0_blocked", 32'(m0_stall_o), 1);
    step();
    m1_stb_i = 1'b0; s_ack_i = 1'b1;
    settle();
    check("drain_m1_ack", 32'(m1_ack_o), 1);
    check("drain_m0_noack", 32'(m0_ack_o), 0);
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0;
    settle();
    check("drain_m1_release", 32'(s_cyc_o), 0);
    check("drain_m0_still_stalled", 32'(m0_stall_o), 1);
    step();
    step();
    settle();
    check("drain_m0_regrant", 32'(m0_stall_o), 0);
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();

    // Abort: m1 drops cyc with two outstanding, late ack is dropped
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 30'h100;
    step();
    settle();
    check("abort_stb", 32'(s_stb_o), 1);
    step();
    step();
    settle();
    check("abort_outst2", 32'(dut.outst), 2);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b1;
    settle();
    check("abort_cyc_same", 32'(s_cyc_o), 0);
    check("abort_ack_same", 32'({m0_ack_o, m1_ack_o}), 0);
    step();
    settle();
    check("abort_late_ack", 32'({m0_ack_o, m1_ack_o}), 0);
    check("abort_outst0", 32'(dut.outst), 0);
    s_ack_i = 1'b0;
    step();

    // Async reset mid-burst, then m0 wins a tie
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 30'h200;
    step();
    settle();
    check("areset_pre_cyc", 32'(s_cyc_o), 1);
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 30'h300;
    settle();
    rst = 1'b0;
    settle();
    check("areset_cyc", 32'(s_cyc_o), 0);
    check("areset_stb", 32'(s_stb_o), 0);
    check("areset_m0_stall", 32'(m0_stall_o), 1);
    check("areset_m1_stall", 32'(m1_stall_o), 1);
    step();
    rst = 1'b1; s_ack_i = 1'b1;
    settle();
    check("areset_no_ack", 32'({m0_ack_o, m1_ack_o}), 0);
    check("areset_idle", 32'(s_cyc_o), 0);
    step();
    s_ack_i = 1'b0;
    settle();
    check("areset_tie_cyc", 32'(s_cyc_o), 1);
    check("areset_tie_adr", 32'(s_adr_o), 32'h200);
    check("areset_tie_m0", 32'(m0_stall_o), 0);
    check("areset_tie_m1", 32'(m1_stall_o), 1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
